// File: rtl/voice_mixer_if.sv
// ---------------------------------------------------------------------------
// voice_mixer_if
//   Bus between the wavetable voices / PWM stage and the voice mixer.
//   Carries the per-voice sample and envelope vectors plus the include mask
//   into the mixer, and the duty-cycle word with its update strobe out of it.
//
//   samples   [16*NUM_VOICES]  voice samples, offset binary, voice i at [16i+15:16i]
//   env       [7*NUM_VOICES]   envelope level per voice, unsigned, voice i at [7i+6:7i]
//   voice_en  [NUM_VOICES]     per-voice include mask
//   dc        [12]             duty cycle to PWM, offset binary
//   dc_valid  [1]              one-cycle strobe when dc updates
//
//   master : voice/PWM side (drives samples, env, voice_en)
//   slave  : mixer side     (drives dc, dc_valid)
// ---------------------------------------------------------------------------
interface voice_mixer_if #(
    parameter int NUM_VOICES = 4
);
    logic [16*NUM_VOICES-1:0] samples;
    logic [7*NUM_VOICES-1:0]  env;
    logic [NUM_VOICES-1:0]    voice_en;
    logic [11:0]              dc;
    logic                     dc_valid;

    modport master (
        output samples, env, voice_en,
        input  dc, dc_valid
    );

    modport slave (
        input  samples, env, voice_en,
        output dc, dc_valid
    );
endinterface

// File: rtl/voice_mixer.sv
// ---------------------------------------------------------------------------
// voice_mixer
//   Envelope-weighted mix of NUM_VOICES wavetable voices into a 12-bit
//   offset-binary PWM duty cycle. A mix-rate timer starts a frame; the frame
//   snapshots all inputs, multiplies/accumulates one voice per clock through
//   a single multiplier, then scales (>>> SHIFT) and saturates the sum.
//
//   Ports:
//     clk      system clock
//     rst_n    asynchronous active-low reset
//     mix_en   enables the mix-rate timer (held at 0 while low)
//     period   timer terminal count, one tick every period+1 clocks
//     ovr_clr  clears the overrun flag (a simultaneous overrun set wins)
//     overrun  sticky: a tick arrived while a frame was in progress
//     busy     high while a frame is being computed
//     bus      voice_mixer_if.slave: samples/env/voice_en in, dc/dc_valid out
//
//   Optional feature: define VOICE_MIXER_DITHER_EN to add a 32-bit LFSR
//   dither below the shift point (round-with-dither instead of floor).
// ---------------------------------------------------------------------------
module voice_mixer #(
    parameter int NUM_VOICES = 4,
    parameter int SHIFT      = 11
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         mix_en,
    input  logic [15:0]  period,
    input  logic         ovr_clr,
    output logic         overrun,
    output logic         busy,
    voice_mixer_if.slave bus
);

    localparam int IDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VOICES - 1);

    typedef enum logic [1:0] {IDLE, ACCUM, SCALE, OUT} state_t;

    state_t                 state, state_next;
    logic [15:0]            count;
    logic                   tick;
    logic [IDX_W-1:0]       idx;
    logic signed [27:0]     acc;
    logic [11:0]            dc_q;
    logic                   dc_valid_c;
    logic [15:0]            snap_sample [NUM_VOICES];
    logic [6:0]             snap_env    [NUM_VOICES];
    logic [NUM_VOICES-1:0]  snap_en;

    // Mix-rate timer: wraps at period, tick lasts exactly one clock.
    assign tick = mix_en && (count == period);

    // NOTE: sequential state always uses non-blocking (<=) so every register
    // samples the pre-edge values of its neighbours.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            count <= '0;
        else if (!mix_en || tick)
            count <= '0;
        else
            count <= count + 16'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // NOTE: every signal written here gets a default first, otherwise a
    // missed branch infers a latch.
    always_comb begin
        state_next = state;
        busy       = 1'b1;
        dc_valid_c = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (tick) state_next = ACCUM;
            end
            ACCUM: if (idx == LAST_IDX) state_next = SCALE;
            SCALE: state_next = OUT;
            OUT: begin
                dc_valid_c = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign bus.dc_valid = dc_valid_c;
    assign bus.dc       = dc_q;

    // Single shared multiplier: current voice, sign-flipped sample times
    // zero-extended envelope.
    logic signed [15:0] cur_s;
    logic signed [7:0]  cur_e;
    logic signed [22:0] prod;

    always_comb begin
        cur_s = $signed(snap_sample[idx] ^ 16'h8000);
        cur_e = $signed({1'b0, snap_env[idx]});
        prod  = 23'(cur_s) * 23'(cur_e);
    end

`ifdef VOICE_MIXER_DITHER_EN
    logic [31:0] lfsr;
    logic        lfsr_fb;

    assign lfsr_fb = lfsr[31] ^ lfsr[29] ^ lfsr[25] ^ lfsr[24];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            lfsr <= 32'h003F_A2C6;
        else if (state == OUT)
            lfsr <= {lfsr[30:0], lfsr_fb};
    end
`endif

    // Scale and saturate; r + 2048 on a 12-bit value is just an MSB flip.
    logic signed [27:0] acc_adj;
    logic signed [27:0] shifted;
    logic [11:0]        scaled;

    always_comb begin
`ifdef VOICE_MIXER_DITHER_EN
        acc_adj = acc + $signed({{(28 - SHIFT){1'b0}}, lfsr[SHIFT-1:0]});
`else
        acc_adj = acc;
`endif
        shifted = acc_adj >>> SHIFT;
        if (shifted > 28'sd2047)
            scaled = 12'hFFF;
        else if (shifted < -28'sd2048)
            scaled = 12'h000;
        else
            scaled = {~shifted[11], shifted[10:0]};
    end

    // NOTE: the snapshot registers are reset along with everything else;
    // they are small, and a mid-frame reset must leave no stale frame data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx     <= '0;
            acc     <= '0;
            dc_q    <= 12'h800;
            snap_en <= '0;
            for (int i = 0; i < NUM_VOICES; i++) begin
                snap_sample[i] <= 16'h8000;
                snap_env[i]    <= '0;
            end
        end else begin
            case (state)
                IDLE: if (tick) begin
                    acc     <= '0;
                    idx     <= '0;
                    snap_en <= bus.voice_en;
                    for (int i = 0; i < NUM_VOICES; i++) begin
                        snap_sample[i] <= bus.samples[16*i +: 16];
                        snap_env[i]    <= bus.env[7*i +: 7];
                    end
                end
                ACCUM: begin
                    if (snap_en[idx]) acc <= acc + 28'(prod);
                    idx <= idx + IDX_W'(1);
                end
                SCALE: dc_q <= scaled;
                default: ;
            endcase
        end
    end

    // Any tick while busy (including the OUT cycle) is an overrun; set wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            overrun <= 1'b0;
        else if (tick && busy)
            overrun <= 1'b1;
        else if (ovr_clr)
            overrun <= 1'b0;
    end

endmodule

// File: tb/tb_voice_mixer.sv
// ---------------------------------------------------------------------------
// tb_voice_mixer
//   Directed bench for voice_mixer (NUM_VOICES=4, SHIFT=11, no dither).
//   Expected duty cycles are hand-computed from sample/envelope values.
// ---------------------------------------------------------------------------
module tb_voice_mixer;

    localparam int NV = 4;

    logic        clk     = 1'b0;
    logic        rst_n   = 1'b0;
    logic        mix_en  = 1'b0;
    logic        ovr_clr = 1'b0;
    logic [15:0] period  = 16'd0;
    logic        overrun;
    logic        busy;

    voice_mixer_if #(.NUM_VOICES(NV)) bus();

    voice_mixer #(.NUM_VOICES(NV), .SHIFT(11)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .mix_en  (mix_en),
        .period  (period),
        .ovr_clr (ovr_clr),
        .overrun (overrun),
        .busy    (busy),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int checks      = 0;
    int errors      = 0;
    int cyc         = 0;
    int valid_count = 0;

    always @(posedge clk) cyc++;
    always @(negedge clk) if (bus.dc_valid === 1'b1) valid_count++;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic set_voice(input int v, input logic [15:0] s, input logic [6:0] e);
        bus.samples[16*v +: 16] = s;
        bus.env[7*v +: 7]       = e;
    endtask

    task automatic clear_voices();
        for (int v = 0; v < NV; v++) set_voice(v, 16'h8000, 7'd0);
        bus.voice_en = '0;
    endtask

    // One frame at period 20; optionally scrambles the inputs once the frame
    // is running to show they were snapshotted.
    task automatic do_frame(input string tag, input bit scramble, input logic [11:0] exp);
        bit          done = 1'b0;
        bit          scr  = 1'b0;
        logic [11:0] got  = 12'hxxx;
        period = 16'd20;
        mix_en = 1'b1;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            if (scramble && busy && !scr) begin
                bus.samples  = '0;
                bus.env      = '1;
                bus.voice_en = '1;
                scr = 1'b1;
            end
            if (bus.dc_valid === 1'b1) begin
                done = 1'b1;
                got  = bus.dc;
            end
        end
        mix_en = 1'b0;
        check({tag, "_done"}, 32'(done), 32'd1);
        check(tag, 32'(got), 32'(exp));
        repeat (3) @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0, first, second, n, v0;
        bit seen;

        clear_voices();

        // Reset state
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_dc", 32'(bus.dc), 32'h800);
        check("rst_dc_valid", 32'(bus.dc_valid), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        repeat (100) @(negedge clk);
        check("idle_no_valid", 32'(valid_count), 32'd0);

        // Single voice full positive, period 99: latency and frame spacing
        set_voice(0, 16'hFFFF, 7'd127);
        bus.voice_en = 4'b0001;
        period = 16'd99;
        c0 = cyc;
        first = -1; second = -1; n = 0;
        mix_en = 1'b1;
        for (int i = 0; i < 250; i++) begin
            @(negedge clk);
            if (bus.dc_valid === 1'b1) begin
                n++;
                if (n == 1) begin
                    first = cyc - c0;
                    check("single_dc", 32'(bus.dc), 32'hFEF);
                end else if (n == 2) begin
                    second = cyc - c0;
                end
            end
        end
        mix_en = 1'b0;
        check("single_first_latency", 32'(first), 32'd105);
        check("single_spacing", 32'(second - first), 32'd100);
        check("single_count", 32'(n), 32'd2);
        repeat (10) @(negedge clk);

        // Saturation
        clear_voices();
        set_voice(0, 16'hFFFF, 7'd127);
        set_voice(1, 16'hFFFF, 7'd127);
        bus.voice_en = 4'b0011;
        do_frame("sat_pos", 1'b0, 12'hFFF);
        set_voice(0, 16'h0000, 7'd127);
        set_voice(1, 16'h0000, 7'd127);
        do_frame("sat_neg", 1'b0, 12'h000);

        // Zero sample, all voices
        for (int v = 0; v < NV; v++) set_voice(v, 16'h8000, 7'd127);
        bus.voice_en = 4'b1111;
        do_frame("zero_sample", 1'b0, 12'h800);

        // Mixed weights, voice3 masked, inputs scrambled after snapshot:
        // 4096*64 - 4096*32 + 16384*1 = 147456, >>>11 = 72 -> 0x848
        set_voice(0, 16'h9000, 7'd64);
        set_voice(1, 16'h7000, 7'd32);
        set_voice(2, 16'hC000, 7'd1);
        set_voice(3, 16'h1234, 7'd127);
        bus.voice_en = 4'b0111;
        do_frame("mixed_snapshot", 1'b1, 12'h848);

        // Zero envelope
        for (int v = 0; v < NV; v++) set_voice(v, 16'hFFFF, 7'd0);
        bus.voice_en = 4'b1111;
        do_frame("zero_env", 1'b0, 12'h800);

        // Floor of a small negative: -1 >>> 11 = -1 -> 0x7FF
        clear_voices();
        set_voice(0, 16'h7FFF, 7'd1);
        bus.voice_en = 4'b0001;
        do_frame("floor_neg", 1'b0, 12'h7FF);

        // Everything masked off
        for (int v = 0; v < NV; v++) set_voice(v, 16'hFFFF, 7'd127);
        bus.voice_en = 4'b0000;
        do_frame("mask_none", 1'b0, 12'h800);

        // Last voice only: 8192*100 = 819200, >>>11 = 400 -> 0x990
        clear_voices();
        set_voice(3, 16'hA000, 7'd100);
        bus.voice_en = 4'b1000;
        do_frame("last_voice", 1'b0, 12'h990);

        // Overrun with period 2: frames start at +2,+11,...,+47 -> 6 frames
        v0 = valid_count;
        period = 16'd2;
        mix_en = 1'b1;
        repeat (50) @(negedge clk);
        mix_en = 1'b0;
        repeat (20) @(negedge clk);
        check("ovr_frames", 32'(valid_count - v0), 32'd6);
        check("ovr_flag", 32'(overrun), 32'd1);
        check("ovr_dc", 32'(bus.dc), 32'h990);
        ovr_clr = 1'b1;
        @(negedge clk);
        ovr_clr = 1'b0;
        check("ovr_clr", 32'(overrun), 32'd0);

        // Set wins over a held clear: busy tick at +5 sets, visible at +6
        ovr_clr = 1'b1;
        mix_en  = 1'b1;
        repeat (6) @(negedge clk);
        check("ovr_set_wins", 32'(overrun), 32'd1);
        @(negedge clk);
        check("ovr_clr_after", 32'(overrun), 32'd0);
        mix_en = 1'b0;
        repeat (10) @(negedge clk);
        ovr_clr = 1'b0;

        // Reset during ACCUM index 2
        clear_voices();
        set_voice(0, 16'hFFFF, 7'd127);
        bus.voice_en = 4'b0001;
        period = 16'd20;
        v0 = valid_count;
        seen = 1'b0;
        mix_en = 1'b1;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            if (busy === 1'b1) seen = 1'b1;
        end
        check("mid_busy_seen", 32'(seen), 32'd1);
        repeat (2) @(negedge clk);
        rst_n  = 1'b0;
        mix_en = 1'b0;
        #1;
        check("mid_rst_dc", 32'(bus.dc), 32'h800);
        check("mid_rst_busy", 32'(busy), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        check("mid_rst_no_valid", 32'(valid_count - v0), 32'd0);
        do_frame("after_rst", 1'b0, 12'hFEF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
